// File: rtl/jtdsp16_pkg.sv
// Shared definitions for the DSP16 program memory: FSM encoding and default geometry.
// No logic; the default constants are overridable per instance.
package jtdsp16_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EXT  = 1'b1
  } state_t;

  localparam int AW_DEF       = 12;
  localparam int DW_DEF       = 16;
  localparam int EXT_WAIT_DEF = 2;
  localparam int CNT_MAX      = 15;

endpackage

// File: rtl/jtdsp16_pmem_ram.sv
// Byte-lane writable single-port-per-direction RAM, 2^AW x DW, one-cycle registered read.
// Never stalls; q holds its last value while re is low.
module jtdsp16_pmem_ram #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic                                          clk,
  input  logic                                          re,
  input  logic [AW-1:0]                                 raddr,
  output logic [DW-1:0]                                 q,
  input  logic                                          we,
  input  logic [AW+((DW > 8) ? $clog2(DW/8) : 0)-1:0]   waddr,
  input  logic [7:0]                                    wdata
);

  localparam int LW = (DW > 8) ? $clog2(DW/8) : 0;

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] widx;
  int unsigned   lane;

  generate
    if (LW > 0) begin : g_lanes
      assign widx = waddr[AW+LW-1:LW];
      assign lane = 32'(waddr[LW-1:0]);
    end else begin : g_one_lane
      assign widx = waddr;
      assign lane = 0;
    end
  endgenerate

  // Read and write share one process so a same-word collision returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[widx][lane*8 +: 8] <= wdata;
    if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/jtdsp16_pmem.sv
// Program memory front end: internal RAM, one-entry hit register, waited external fetch.
// Internal/hit fetches return next cycle; external fetches hold busy and drop rd until done.
module jtdsp16_pmem
  import jtdsp16_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int EXT_WAIT = EXT_WAIT_DEF
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          ext_mode,
  input  logic                                          rd,
  input  logic [15:0]                                   addr,
  output logic [DW-1:0]                                 dout,
  output logic                                          dok,
  output logic                                          busy,
  output logic                                          ext_cs,
  output logic [15:0]                                   ext_addr,
  input  logic [DW-1:0]                                 ext_data,
  input  logic                                          ext_ok,
  input  logic [AW+((DW > 8) ? $clog2(DW/8) : 0)-1:0]   prog_addr,
  input  logic [7:0]                                    prog_data,
  input  logic                                          prog_we
);

  localparam logic [3:0] WAIT_CNT = 4'(EXT_WAIT);
  localparam logic [3:0] CNT_TOP  = 4'(CNT_MAX);

  state_t        state, state_nxt;
  logic [3:0]    cnt;
  logic          mode_q;
  logic          hit_vld;
  logic [15:0]   hit_tag;
  logic [DW-1:0] hit_dat;
  logic [DW-1:0] dout_r;
  logic [DW-1:0] ram_q;
  logic          sel_ram;
  logic          dok_r;
  logic [15:0]   ext_addr_r;

  logic is_int, mode_chg, hit, idle;
  logic acc_int, acc_hit, start_ext, ext_done;

  assign is_int    = !ext_mode && ((addr >> AW) == 16'd0);
  // A mode change invalidates the hit entry in the same cycle it is seen.
  assign mode_chg  = ext_mode != mode_q;
  assign hit       = hit_vld && !mode_chg && (addr == hit_tag);
  assign idle      = state == IDLE;
  assign acc_int   = idle && rd && is_int;
  assign acc_hit   = idle && rd && !is_int && hit;
  assign start_ext = idle && rd && !is_int && !hit;
  assign ext_done  = (state == EXT) && (cnt >= WAIT_CNT) && ext_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    ext_cs    = 1'b0;
    case (state)
      IDLE: begin
        if (start_ext) state_nxt = EXT;
      end
      EXT: begin
        busy   = 1'b1;
        ext_cs = 1'b1;
        if (ext_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 4'd0;
      mode_q     <= 1'b0;
      hit_vld    <= 1'b0;
      hit_tag    <= 16'd0;
      hit_dat    <= '0;
      dout_r     <= '0;
      sel_ram    <= 1'b0;
      dok_r      <= 1'b0;
      ext_addr_r <= 16'd0;
    end else begin
      mode_q <= ext_mode;
      dok_r  <= acc_int || acc_hit || ext_done;

      if (start_ext)                         cnt <= 4'd0;
      else if (state == EXT && cnt != CNT_TOP) cnt <= cnt + 4'd1;

      if (start_ext) ext_addr_r <= addr;

      if (ext_done) begin
        hit_tag <= ext_addr_r;
        hit_dat <= ext_data;
      end
      if (mode_chg)      hit_vld <= 1'b0;
      else if (ext_done) hit_vld <= 1'b1;

      // dout is muxed so the RAM's registered output needs no second copy.
      if (acc_int) begin
        sel_ram <= 1'b1;
      end else if (acc_hit) begin
        sel_ram <= 1'b0;
        dout_r  <= hit_dat;
      end else if (ext_done) begin
        sel_ram <= 1'b0;
        dout_r  <= ext_data;
      end
    end
  end

  assign dout     = sel_ram ? ram_q : dout_r;
  assign dok      = dok_r;
  assign ext_addr = ext_addr_r;

  jtdsp16_pmem_ram #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clk   (clk),
    .re    (acc_int),
    .raddr (addr[AW-1:0]),
    .q     (ram_q),
    .we    (prog_we),
    .waddr (prog_addr),
    .wdata (prog_data)
  );

endmodule

// File: tb/tb_jtdsp16_pmem.sv
// Randomized bench for jtdsp16_pmem against a transaction-level memory/hit model.
module tb_jtdsp16_pmem;

  localparam int AW = 12;
  localparam int DW = 16;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ext_mode = 1'b0;
  logic          rd = 1'b0;
  logic [15:0]   addr = 16'd0;
  logic [DW-1:0] dout;
  logic          dok, busy, ext_cs;
  logic [15:0]   ext_addr;
  logic [DW-1:0] ext_data;
  logic          ext_ok = 1'b1;
  logic [12:0]   prog_addr = 13'd0;
  logic [7:0]    prog_data = 8'd0;
  logic          prog_we = 1'b0;

  always #5 clk = ~clk;

  jtdsp16_pmem #(.AW(AW), .DW(DW), .EXT_WAIT(EW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ext_mode  (ext_mode),
    .rd        (rd),
    .addr      (addr),
    .dout      (dout),
    .dok       (dok),
    .busy      (busy),
    .ext_cs    (ext_cs),
    .ext_addr  (ext_addr),
    .ext_data  (ext_data),
    .ext_ok    (ext_ok),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .prog_we   (prog_we)
  );

  // External memory contents as a fixed function of the word address.
  function automatic logic [15:0] ext_fn(input logic [15:0] a);
    if (a == 16'h1000) return 16'hBEEF;
    return (a * 16'd7) ^ 16'h5A3C;
  endfunction

  assign ext_data = ext_fn(ext_addr);

  logic [15:0] mem_m [4096];
  logic        m_hit_vld = 1'b0;
  logic [15:0] m_hit_tag = 16'd0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [15:0] pool [5] = '{16'h1000, 16'h1001, 16'h2000, 16'h8000, 16'hFFFF};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  function automatic logic [15:0] rand_int_addr();
    int r;
    r = $urandom_range(0, 127);
    return (r < 64) ? 16'(r) : 16'(16'h0FC0 + (r - 64));
  endfunction

  task automatic model_write(input logic [12:0] ba, input logic [7:0] b);
    if (ba[0]) mem_m[ba[12:1]][15:8] = b;
    else       mem_m[ba[12:1]][7:0]  = b;
  endtask

  task automatic prog(input logic [12:0] ba, input logic [7:0] b);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = ba; prog_data = b;
    @(negedge clk);
    prog_we = 1'b0;
    model_write(ba, b);
  endtask

  task automatic set_mode(input logic m);
    @(negedge clk);
    if (m != ext_mode) m_hit_vld = 1'b0;
    ext_mode = m;
  endtask

  task automatic fetch(input logic [15:0] a, input bit rnd_ok, input bit exact);
    logic [15:0] want;
    bit is_ext, hit, bad;
    int n;
    is_ext = ext_mode || (a >= 16'h1000);
    hit    = is_ext && m_hit_vld && (m_hit_tag == a);
    want   = is_ext ? ext_fn(a) : mem_m[a[11:0]];
    @(negedge clk);
    rd = 1'b1; addr = a;
    ext_ok = rnd_ok ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    rd = 1'b0;
    if (!is_ext || hit) begin
      chk("fast_dok", dok, 1);
      chk("fast_no_cs", ext_cs, 0);
      chk("fast_dout", dout, want);
    end else begin
      chk("ext_start", {ext_cs, busy}, 2'b11);
      chk("ext_addr", ext_addr, a);
      n = 0; bad = 0;
      while (ext_cs && n < 100) begin
        if (dok || ext_addr != a) bad = 1;
        n++;
        rd = 1'($urandom_range(0, 1));
        addr = 16'($urandom);
        ext_ok = rnd_ok ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
      end
      rd = 1'b0; ext_ok = 1'b1;
      chk("ext_timeout", ext_cs, 0);
      chk("ext_held", bad, 0);
      chk("ext_dok", dok, 1);
      chk("ext_dout", dout, want);
      chk("ext_busy", busy, 0);
      if (exact) chk("ext_cycles", n, EW + 1);
      else       chk("ext_min_cycles", n >= EW + 1, 1);
      m_hit_vld = 1'b1;
      m_hit_tag = a;
    end
  endtask

  task automatic burst(input int len);
    logic [15:0] q[$];
    logic [15:0] a, want;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i > 0) begin
        want = q.pop_front();
        chk("burst_dok", dok, 1);
        chk("burst_dout", dout, want);
      end
      a = rand_int_addr();
      rd = 1'b1; addr = a;
      q.push_back(mem_m[a[11:0]]);
    end
    @(negedge clk);
    rd = 1'b0;
    want = q.pop_front();
    chk("burst_dok", dok, 1);
    chk("burst_dout", dout, want);
  endtask

  initial begin
    logic [15:0] a, old;
    bit r;
    int op;

    #1;
    chk("rst_dout", dout, 0);
    chk("rst_dok", dok, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cs", ext_cs, 0);
    chk("rst_ext_addr", ext_addr, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Programming two bytes then reading the word back.
    prog(13'd0, 8'h34);
    prog(13'd1, 8'h12);
    fetch(16'h0000, 0, 0);
    chk("prog_word", dout, 16'h1234);

    for (int w = 1; w < 64; w++) begin
      prog(13'({w[11:0], 1'b0}), 8'($urandom));
      prog(13'({w[11:0], 1'b1}), 8'($urandom));
    end
    for (int w = 12'hFC0; w < 4096; w++) begin
      prog(13'({w[11:0], 1'b0}), 8'($urandom));
      prog(13'({w[11:0], 1'b1}), 8'($urandom));
    end

    // External fetch, hit, and hit invalidation by mode change.
    fetch(16'h1000, 0, 1);
    chk("ext_beef", dout, 16'hBEEF);
    fetch(16'h1000, 0, 1);
    chk("hit_beef", dout, 16'hBEEF);
    set_mode(1'b1);
    fetch(16'h1000, 0, 1);
    fetch(16'h0005, 0, 1);
    set_mode(1'b0);
    fetch(16'h0FFF, 0, 0);

    // Write and read of the same word in one cycle returns the old word.
    old = mem_m[0];
    @(negedge clk);
    rd = 1'b1; addr = 16'h0000;
    prog_we = 1'b1; prog_addr = 13'd0; prog_data = 8'hAA;
    @(negedge clk);
    rd = 1'b0; prog_we = 1'b0;
    chk("collide_dok", dok, 1);
    chk("collide_old", dout, old);
    model_write(13'd0, 8'hAA);
    fetch(16'h0000, 0, 0);
    chk("collide_new_lo", dout[7:0], 8'hAA);

    // Reset in the middle of a stalled external fetch.
    @(negedge clk);
    rd = 1'b1; addr = 16'h2000; ext_ok = 1'b0;
    @(negedge clk);
    rd = 1'b0;
    chk("stall_cs", ext_cs, 1);
    repeat (10) @(negedge clk);
    chk("stall_still_cs", ext_cs, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_cs", ext_cs, 0);
    chk("abort_busy", busy, 0);
    chk("abort_dok", dok, 0);
    chk("abort_ext_addr", ext_addr, 0);
    chk("abort_dout", dout, 0);
    repeat (2) @(negedge clk);
    chk("abort_no_dok", dok, 0);
    rst_n = 1'b1;
    ext_ok = 1'b1;
    m_hit_vld = 1'b0;
    fetch(16'h2000, 0, 1);
    fetch(16'h0000, 0, 0);
    chk("ram_kept", dout, mem_m[0]);

    for (int it = 0; it < 400; it++) begin
      op = $urandom_range(0, 9);
      r  = 1'($urandom_range(0, 1));
      case (op)
        0, 1: begin
          a = rand_int_addr();
          prog({a[11:0], r}, 8'($urandom));
        end
        2, 3: fetch(rand_int_addr(), r, !r);
        4, 5, 6: fetch(pool[$urandom_range(0, 4)], r, !r);
        7: set_mode(!ext_mode);
        8: begin
          set_mode(1'b0);
          burst($urandom_range(2, 6));
        end
        default: begin
          @(negedge clk);
          chk("dok_single", dok, 0);
        end
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
